// File: rtl/gray2bin_stream.sv
// Streaming Gray-to-binary decoder with a registered output stage and a +/-1 step checker.
// Optional saturating step-error counter enabled by defining GRAY2BIN_ERRCNT_EN.
module gray2bin_stream #(
    parameter int WIDTH    = 4,
    parameter int ERRCNT_W = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [WIDTH-1:0]    in_gray,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [WIDTH-1:0]    out_bin,
    output logic                out_dir,
    output logic                out_first,
    output logic                out_step_err,
    output logic [ERRCNT_W-1:0] err_count,
    input  logic                resync
);

    logic [WIDTH-1:0] dec_bin;
    logic [WIDTH-1:0] prev_bin_reg;
    logic [WIDTH-1:0] delta;
    logic             out_valid_reg;
    logic [WIDTH-1:0] out_bin_reg;
    logic             out_dir_reg;
    logic             out_first_reg;
    logic             out_step_err_reg;
    logic             first_reg;
    logic             accept;
    logic             first_now;
    logic             step_up;
    logic             step_dn;
    logic             step_bad;

    // Each binary bit is the XOR of all Gray bits at or above it.
    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_dec
            assign dec_bin[gi] = ^in_gray[WIDTH-1:gi];
        end
    endgenerate

    assign in_ready  = !out_valid_reg || out_ready;
    assign accept    = in_valid && in_ready;
    assign first_now = first_reg || resync;
    assign delta     = dec_bin - prev_bin_reg;
    assign step_up   = (delta == WIDTH'(1));
    assign step_dn   = (delta == {WIDTH{1'b1}});
    assign step_bad  = !first_now && !(step_up || step_dn);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_reg    <= 1'b0;
            out_bin_reg      <= '0;
            out_dir_reg      <= 1'b0;
            out_first_reg    <= 1'b0;
            out_step_err_reg <= 1'b0;
            prev_bin_reg     <= '0;
            first_reg        <= 1'b1;
        end else begin
            if (accept) begin
                out_valid_reg    <= 1'b1;
                out_bin_reg      <= dec_bin;
                out_first_reg    <= first_now;
                out_dir_reg      <= !first_now && step_up;
                out_step_err_reg <= step_bad;
                prev_bin_reg     <= dec_bin;
                first_reg        <= 1'b0;
            end else begin
                if (out_ready) begin
                    out_valid_reg <= 1'b0;
                end
                // A resync without an accept arms the flag for the next word.
                if (resync) begin
                    first_reg <= 1'b1;
                end
            end
        end
    end

`ifdef GRAY2BIN_ERRCNT_EN
    logic [ERRCNT_W-1:0] err_count_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_count_reg <= '0;
        end else if (accept && step_bad && (err_count_reg != {ERRCNT_W{1'b1}})) begin
            err_count_reg <= err_count_reg + ERRCNT_W'(1);
        end
    end

    assign err_count = err_count_reg;
`else
    assign err_count = '0;
`endif

    assign out_valid    = out_valid_reg;
    assign out_bin      = out_bin_reg;
    assign out_dir      = out_dir_reg;
    assign out_first    = out_first_reg;
    assign out_step_err = out_step_err_reg;

endmodule

// File: tb/tb_gray2bin_stream.sv
// Directed self-checking bench for gray2bin_stream (WIDTH=4, ERRCNT_W=8).
// Counter expectations follow GRAY2BIN_ERRCNT_EN: zero when the counter is compiled out.
module tb_gray2bin_stream;

`ifdef GRAY2BIN_ERRCNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] in_gray;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] out_bin;
    logic       out_dir;
    logic       out_first;
    logic       out_step_err;
    logic [7:0] err_count;
    logic       resync;

    int passed;
    int total;

    gray2bin_stream #(.WIDTH(4), .ERRCNT_W(8)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_gray      (in_gray),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_bin      (out_bin),
        .out_dir      (out_dir),
        .out_first    (out_first),
        .out_step_err (out_step_err),
        .err_count    (err_count),
        .resync       (resync)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One-cycle transfer; returns 1 ns after the accepting edge.
    task automatic push(input logic [3:0] g, input logic rs);
        @(negedge clk);
        in_valid = 1'b1;
        in_gray  = g;
        resync   = rs;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        resync   = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; in_gray = 4'd0; out_ready = 1'b1; resync = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        total++; if (out_valid !== 1'b0) $display("FAIL reset_valid got=%b exp=0", out_valid); else passed++;
        total++; if (out_bin !== 4'd0) $display("FAIL reset_bin got=%0d exp=0", out_bin); else passed++;
        total++; if ({out_dir, out_first, out_step_err} !== 3'b000) $display("FAIL reset_flags got=%b exp=000", {out_dir, out_first, out_step_err}); else passed++;
        total++; if (err_count !== 8'd0) $display("FAIL reset_errcnt got=%0d exp=0", err_count); else passed++;
        @(negedge clk);
        rst = 1'b0;
        #1;
        total++; if (in_ready !== 1'b1) $display("FAIL reset_ready got=%b exp=1", in_ready); else passed++;
        $display("reset: out_valid=%b out_bin=%0d err_count=%0d", out_valid, out_bin, err_count);
    endtask

    task automatic test_count_up();
        logic [3:0] gv [5];
        gv = '{4'b0000, 4'b0001, 4'b0011, 4'b0010, 4'b0110};
        for (int i = 0; i < 5; i++) begin
            push(gv[i], 1'b0);
            total++; if (out_valid !== 1'b1) $display("FAIL up_valid[%0d] got=%b exp=1", i, out_valid); else passed++;
            total++; if (out_bin !== 4'(i)) $display("FAIL up_bin[%0d] got=%0d exp=%0d", i, out_bin, i); else passed++;
            total++; if (out_first !== (i == 0)) $display("FAIL up_first[%0d] got=%b exp=%b", i, out_first, (i == 0)); else passed++;
            total++; if (out_dir !== (i != 0)) $display("FAIL up_dir[%0d] got=%b exp=%b", i, out_dir, (i != 0)); else passed++;
            total++; if (out_step_err !== 1'b0) $display("FAIL up_err[%0d] got=%b exp=0", i, out_step_err); else passed++;
            $display("count_up: gray=%b bin=%0d first=%b dir=%b err=%b", gv[i], out_bin, out_first, out_dir, out_step_err);
        end
        total++; if (err_count !== 8'd0) $display("FAIL up_errcnt got=%0d exp=0", err_count); else passed++;
        @(posedge clk);
        #1;
        total++; if (out_valid !== 1'b0) $display("FAIL drain_valid got=%b exp=0", out_valid); else passed++;
        total++; if (out_bin !== 4'd4) $display("FAIL drain_hold got=%0d exp=4", out_bin); else passed++;
        $display("drain: out_valid=%b out_bin=%0d", out_valid, out_bin);
    endtask

    task automatic test_wrap();
        logic [3:0] gv [3];
        logic [3:0] bv [3];
        logic       dv [3];
        gv = '{4'b1000, 4'b0000, 4'b1000};
        bv = '{4'd15, 4'd0, 4'd15};
        dv = '{1'b0, 1'b1, 1'b0};
        for (int i = 0; i < 3; i++) begin
            push(gv[i], (i == 0));
            total++; if (out_bin !== bv[i]) $display("FAIL wrap_bin[%0d] got=%0d exp=%0d", i, out_bin, bv[i]); else passed++;
            total++; if (out_dir !== dv[i]) $display("FAIL wrap_dir[%0d] got=%b exp=%b", i, out_dir, dv[i]); else passed++;
            total++; if (out_first !== (i == 0)) $display("FAIL wrap_first[%0d] got=%b exp=%b", i, out_first, (i == 0)); else passed++;
            total++; if (out_step_err !== 1'b0) $display("FAIL wrap_err[%0d] got=%b exp=0", i, out_step_err); else passed++;
            $display("wrap: gray=%b bin=%0d dir=%b first=%b err=%b", gv[i], out_bin, out_dir, out_first, out_step_err);
        end
    endtask

    task automatic test_step_err();
        logic [3:0] gv [3];
        logic [3:0] bv [3];
        logic       ev [3];
        gv = '{4'b0000, 4'b0100, 4'b0100};
        bv = '{4'd0, 4'd7, 4'd7};
        ev = '{1'b0, 1'b1, 1'b1};
        for (int i = 0; i < 3; i++) begin
            push(gv[i], 1'b0);
            total++; if (out_bin !== bv[i]) $display("FAIL err_bin[%0d] got=%0d exp=%0d", i, out_bin, bv[i]); else passed++;
            total++; if (out_step_err !== ev[i]) $display("FAIL err_flag[%0d] got=%b exp=%b", i, out_step_err, ev[i]); else passed++;
            $display("step_err: gray=%b bin=%0d err=%b err_count=%0d", gv[i], out_bin, out_step_err, err_count);
        end
        total++; if (err_count !== (CNT_EN ? 8'd2 : 8'd0)) $display("FAIL err_count got=%0d exp=%0d", err_count, (CNT_EN ? 2 : 0)); else passed++;
    endtask

    task automatic test_back_to_back();
        @(posedge clk);
        #1;
        @(negedge clk);
        out_ready = 1'b0; in_valid = 1'b1; in_gray = 4'b0000; resync = 1'b1;
        @(posedge clk);
        #1;
        resync = 1'b0; in_gray = 4'b0001;
        total++; if (out_valid !== 1'b1) $display("FAIL stall_valid got=%b exp=1", out_valid); else passed++;
        total++; if (in_ready !== 1'b0) $display("FAIL stall_ready got=%b exp=0", in_ready); else passed++;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            total++; if ({out_bin, out_first, in_ready} !== {4'd0, 1'b1, 1'b0}) $display("FAIL stall_hold[%0d] got=%0d/%b/%b exp=0/1/0", i, out_bin, out_first, in_ready); else passed++;
            $display("stall: cycle=%0d out_bin=%0d in_ready=%b", i, out_bin, in_ready);
        end
        out_ready = 1'b1;
        #1;
        total++; if (in_ready !== 1'b1) $display("FAIL release_ready got=%b exp=1", in_ready); else passed++;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        total++; if ({out_valid, out_bin, out_dir, out_first} !== {1'b1, 4'd1, 1'b1, 1'b0}) $display("FAIL release_word got=%b/%0d/%b/%b exp=1/1/1/0", out_valid, out_bin, out_dir, out_first); else passed++;
        $display("release: out_valid=%b out_bin=%0d dir=%b", out_valid, out_bin, out_dir);
    endtask

    task automatic test_saturate();
        for (int k = 1; k <= 260; k++) begin
            push((k % 2 == 1) ? 4'b0100 : 4'b0000, 1'b0);
            if (k == 250) begin
                total++; if (err_count !== (CNT_EN ? 8'd252 : 8'd0)) $display("FAIL sat_mid got=%0d exp=%0d", err_count, (CNT_EN ? 252 : 0)); else passed++;
                $display("saturate: errors=%0d err_count=%0d", k, err_count);
            end
        end
        total++; if (err_count !== (CNT_EN ? 8'd255 : 8'd0)) $display("FAIL sat_end got=%0d exp=%0d", err_count, (CNT_EN ? 255 : 0)); else passed++;
        total++; if (out_step_err !== 1'b1) $display("FAIL sat_flag got=%b exp=1", out_step_err); else passed++;
        $display("saturate: errors=260 err_count=%0d", err_count);
    endtask

    task automatic test_resync();
        push(4'b0101, 1'b1);
        total++; if ({out_bin, out_first, out_step_err} !== {4'd6, 1'b1, 1'b0}) $display("FAIL resync_word got=%0d/%b/%b exp=6/1/0", out_bin, out_first, out_step_err); else passed++;
        total++; if (err_count !== (CNT_EN ? 8'd255 : 8'd0)) $display("FAIL resync_errcnt got=%0d exp=%0d", err_count, (CNT_EN ? 255 : 0)); else passed++;
        $display("resync: bin=%0d first=%b err=%b", out_bin, out_first, out_step_err);
        @(negedge clk);
        resync = 1'b1;
        @(negedge clk);
        resync = 1'b0;
        push(4'b0111, 1'b0);
        total++; if ({out_bin, out_first, out_dir, out_step_err} !== {4'd5, 1'b1, 1'b0, 1'b0}) $display("FAIL resync_idle got=%0d/%b/%b/%b exp=5/1/0/0", out_bin, out_first, out_dir, out_step_err); else passed++;
        $display("resync_idle: bin=%0d first=%b", out_bin, out_first);
    endtask

    task automatic test_reset_mid();
        push(4'b0010, 1'b0);
        out_ready = 1'b0;
        total++; if (out_valid !== 1'b1) $display("FAIL mid_pre_valid got=%b exp=1", out_valid); else passed++;
        #2;
        rst = 1'b1;
        #1;
        total++; if (out_valid !== 1'b0) $display("FAIL mid_async_valid got=%b exp=0", out_valid); else passed++;
        total++; if ({out_bin, err_count} !== 12'd0) $display("FAIL mid_async_clear got=%0d/%0d exp=0/0", out_bin, err_count); else passed++;
        $display("reset_mid: out_valid=%b out_bin=%0d", out_valid, out_bin);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        out_ready = 1'b1;
        push(4'b0011, 1'b0);
        total++; if ({out_valid, out_bin, out_first, out_step_err} !== {1'b1, 4'd2, 1'b1, 1'b0}) $display("FAIL mid_first got=%b/%0d/%b/%b exp=1/2/1/0", out_valid, out_bin, out_first, out_step_err); else passed++;
        $display("reset_mid: after release bin=%0d first=%b", out_bin, out_first);
    endtask

    initial begin
        passed = 0;
        total  = 0;
        test_reset();
        test_count_up();
        test_wrap();
        test_step_err();
        test_back_to_back();
        test_saturate();
        test_resync();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/gray2bin_stream.md
Name: gray2bin_stream

Overview:
- Decoder-side counterpart to the team's binary-to-Gray encoder.
- Accepts a stream of Gray-coded words over valid/ready and returns the binary equivalent, registered, one cycle later.
- Checks that each accepted word is exactly one count step (±1, modulo 2^WIDTH) from the previously accepted word, and reports the direction of the step.
- Sits on the receive side of Gray-coded counter/pointer links.

Parameters:
- WIDTH, 4, bit width of the Gray input and binary output (≥2).
- ERRCNT_W, 8, width of the saturating step-error counter.

Ports:
- clk  input  1  single clock, rising edge
- rst  input  1  asynchronous reset, active-high
- in_valid  input  1  in_gray is valid this cycle
- in_ready  output  1  block can accept a word this cycle
- in_gray  input  WIDTH  Gray-coded word
- out_valid  output  1  out_bin/out_* fields valid
- out_ready  input  1  downstream accepts output this cycle
- out_bin  output  WIDTH  decoded binary value
- out_dir  output  1  1 = step +1, 0 = step -1 (meaningful only when out_step_err=0 and not first)
- out_first  output  1  word is first accepted since reset/resync (no step check)
- out_step_err  output  1  binary delta from previous word is not ±1 mod 2^WIDTH
- err_count  output  ERRCNT_W  saturating count of step errors
- resync  input  1  synchronous: next accepted word is treated as first

Behaviour:
- Reset (rst=1, async):
  - out_valid=0, out_bin=0, out_dir=0, out_first=0, out_step_err=0, err_count=0.
  - Previous-value register cleared; first-flag set.
  - in_ready=1 as soon as reset deasserts.
- Decode:
  - bin[WIDTH-1] = g[WIDTH-1]; bin[i] = bin[i+1] XOR g[i], for i down to 0.
  - Combinational from in_gray, then registered into the output stage.
- Handshake:
  - in_ready = !out_valid || out_ready (single output register; no bubble under continuous flow).
  - Accept = in_valid && in_ready. Latency 1 cycle: on accept, output fields load at the next edge and out_valid=1.
  - When out_valid && out_ready && !accept: out_valid→0. Fields hold their last values.
  - Stall (out_valid && !out_ready): all out_* fields stable; in_ready=0.
  - in_gray may change while in_valid=0; it is only sampled on accept.
- Step check (on accept, d = (bin - prev_bin) mod 2^WIDTH):
  - First word (first-flag set): out_first=1, out_step_err=0, out_dir=0; clear first-flag.
  - d==1: out_dir=1, out_step_err=0.
  - d==2^WIDTH-1: out_dir=0, out_step_err=0.
  - Any other d, including 0 (repeat): out_step_err=1, out_dir=0, err_count += 1 (saturates at all-ones).
  - prev_bin ← bin on every accept.
- Wrap-around: 15→0 (WIDTH=4) is +1 and 0→15 is -1; neither is an error.
- resync:
  - Sets first-flag; does not touch err_count or the output register.
  - If asserted in the same cycle as an accept, that accepted word is the first.
- Reset mid-transfer: the pending output is discarded (out_valid=0); no handshake completion is implied.

Optional Feature:
- Macro: GRAY2BIN_ERRCNT_EN.
- Defined: err_count implemented as above.
- Undefined: no counter register; err_count tied to 0. out_step_err still produced.

Test Plan:
- Reset, then feed 0000,0001,0011,0010,0110 with out_ready=1 → out_bin 0,1,2,3,4 one cycle after each accept; out_first=1 on the first word only; out_dir=1; err_count=0.
- Gray 1000 then 0000 then 1000 → bins 15,0,15; second word dir=1, third dir=0; no errors.
- Sequence 0000,0100 (bin 0→7), then 0100 repeated → out_step_err=1 on both; err_count=2.
- Hold out_ready=0 with in_valid=1 → in_ready=0 after the first accept; out_bin stable; release → next word accepted in the same cycle as the drain, no bubble.
- 260 errors with ERRCNT_W=8 → err_count saturates at 255; resync with 0101 → out_first=1, no error, bin 6.
- Assert rst while out_valid=1 → out_valid=0 immediately (async); after release, the first word is flagged out_first=1.
